// File: rtl/soc_system_pio_pkg.sv
// soc_system_pio_pkg
// Shared definitions for the PIO Avalon-MM initiator:
//   - pio_state_t : transfer sequencer states
//   - pio_reg_t   : word offsets of the PIO slave registers
package soc_system_pio_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_RD,
        ST_RSP,
        ST_EVT
    } pio_state_t;

    typedef enum logic [1:0] {
        PIO_REG_DATA      = 2'd0,
        PIO_REG_DIRECTION = 2'd1,
        PIO_REG_IRQ_MASK  = 2'd2,
        PIO_REG_EDGE_CAP  = 2'd3
    } pio_reg_t;

endpackage

// File: rtl/soc_system_pio_master.sv
// soc_system_pio_master
// Avalon-MM initiator for one zero-wait-state PIO slave. Turns single-beat
// local commands into register writes/reads and services the PIO interrupt
// by reading the data register on its own, reported as an event.
// Ports:
//   clk, reset_n                  clock, async active-low reset
//   cmd_valid/ready/write/addr/wdata  local command handshake
//   rsp_valid, rsp_data           one-cycle command completion, read data
//   evt_valid, evt_data           one-cycle irq-read completion, data value
//   irq                           PIO interrupt level
//   chipselect, write_n, address, writedata, readdata   Avalon-MM master side
module soc_system_pio_master
    import soc_system_pio_pkg::*;
#(
    parameter int ADDR_W    = 2,
    parameter int DATA_W    = 32,
    parameter int READ_WAIT = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              evt_valid,
    output logic [DATA_W-1:0] evt_data,
    input  logic              irq,
    output logic              chipselect,
    output logic              write_n,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] writedata,
    input  logic [DATA_W-1:0] readdata
);

    // READ_WAIT=0 still needs a one-bit counter to keep the vector legal.
    localparam int              CNT_W     = (READ_WAIT > 0) ? $clog2(READ_WAIT + 1) : 1;
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(READ_WAIT);

    pio_state_t       r_state;
    pio_state_t       w_next;
    logic             r_irq_q;
    logic             r_irq_pend;
    logic             r_is_evt;
    logic [CNT_W-1:0] r_wait_cnt;
    logic             w_irq_edge;
    logic             w_launch_evt;
    logic             w_accept;
    logic             w_rd_done;

    assign cmd_ready    = (r_state == ST_IDLE) && !r_irq_pend;
    assign w_irq_edge   = irq && !r_irq_q;
    assign w_launch_evt = (r_state == ST_IDLE) && r_irq_pend;
    assign w_accept     = cmd_ready && cmd_valid;
    assign w_rd_done    = (r_state == ST_RD) && (r_wait_cnt == WAIT_LAST);

    // Pending interrupt has priority over a new command in IDLE.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_launch_evt) begin
                    w_next = ST_RD;
                end else if (w_accept) begin
                    w_next = cmd_write ? ST_WR : ST_RD;
                end
            end
            ST_WR:   w_next = ST_RSP;
            ST_RD: begin
                if (w_rd_done) begin
                    w_next = r_is_evt ? ST_EVT : ST_RSP;
                end
            end
            ST_RSP:  w_next = ST_IDLE;
            ST_EVT:  w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // A fresh edge always wins over the clear, so an edge coinciding with
    // the launch of the event read is not dropped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_irq_q    <= 1'b0;
            r_irq_pend <= 1'b0;
        end else begin
            r_irq_q    <= irq;
            r_irq_pend <= w_irq_edge || (r_irq_pend && !w_launch_evt);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_is_evt  <= 1'b0;
            address   <= '0;
            writedata <= '0;
        end else if (w_launch_evt) begin
            r_is_evt <= 1'b1;
            address  <= ADDR_W'(PIO_REG_DATA);
        end else if (w_accept) begin
            r_is_evt  <= 1'b0;
            address   <= cmd_addr;
            writedata <= cmd_wdata;
        end
    end

    // Counts RD cycles; parked at zero outside RD so each read starts clean.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wait_cnt <= '0;
        end else if ((r_state == ST_RD) && !w_rd_done) begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
        end else begin
            r_wait_cnt <= '0;
        end
    end

    // Strobes and pulses are decoded from the next state so they line up
    // with the state they belong to while still coming from flops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chipselect <= 1'b0;
            write_n    <= 1'b1;
            rsp_valid  <= 1'b0;
            evt_valid  <= 1'b0;
        end else begin
            chipselect <= (w_next == ST_WR) || (w_next == ST_RD);
            write_n    <= (w_next != ST_WR);
            rsp_valid  <= (w_next == ST_RSP);
            evt_valid  <= (w_next == ST_EVT);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_data <= '0;
            evt_data <= '0;
        end else if (r_state == ST_WR) begin
            rsp_data <= '0;
        end else if (w_rd_done) begin
            if (r_is_evt) begin
                evt_data <= readdata;
            end else begin
                rsp_data <= readdata;
            end
        end
    end

endmodule

// File: tb/tb_soc_system_pio_master.sv
// tb_soc_system_pio_master
// Drives soc_system_pio_master against a small PIO slave model (registered
// readdata, irq = data & mask) and checks each scenario against expected
// transaction-level behaviour.
module tb_soc_system_pio_master;

    localparam int AW = 2;
    localparam int DW = 32;
    localparam int RW = 3;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;
    logic          evt_valid;
    logic [DW-1:0] evt_data;
    logic          irq;
    logic          chipselect;
    logic          write_n;
    logic [AW-1:0] address;
    logic [DW-1:0] writedata;
    logic [DW-1:0] readdata = '0;

    logic [DW-1:0] inPort;
    logic [DW-1:0] slaveRegs [4] = '{default: '0};
    logic [DW-1:0] shadow    [4] = '{default: '0};

    int nChecks   = 0;
    int nFails    = 0;
    int rspCount  = 0;
    int evtCount  = 0;

    soc_system_pio_master #(.ADDR_W(AW), .DATA_W(DW), .READ_WAIT(RW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .evt_valid  (evt_valid),
        .evt_data   (evt_data),
        .irq        (irq),
        .chipselect (chipselect),
        .write_n    (write_n),
        .address    (address),
        .writedata  (writedata),
        .readdata   (readdata)
    );

    always #5 clk = ~clk;

    assign irq = |(inPort & slaveRegs[2]);

    // PIO slave: zero-wait writes, registered reads, data register reads in_port
    always @(posedge clk) begin
        if (rsp_valid) rspCount++;
        if (evt_valid) evtCount++;
        if (chipselect && !write_n) slaveRegs[address] <= writedata;
        readdata <= (address == 2'd0) ? inPort : slaveRegs[address];
    end

    task automatic run_cmd(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [DW-1:0] expRd, input string tag);
        int startRsp;
        int waitCycles;
        logic [DW-1:0] expRsp;
        expRsp = wr ? '0 : expRd;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
        waitCycles = 0;
        while (!cmd_ready && waitCycles < 20) begin
            @(negedge clk);
            waitCycles++;
        end
        nChecks++;
        if (cmd_ready !== 1'b1) begin
            nFails++;
            $display("[TB] FAIL %s_ready: cmd_ready=%b required 1", tag, cmd_ready);
        end
        startRsp = rspCount;
        @(negedge clk);
        cmd_valid = 1'b0;
        if (wr) begin
            nChecks++;
            if ({chipselect, write_n, address, writedata} !== {1'b1, 1'b0, a, d}) begin
                nFails++;
                $display("[TB] FAIL %s_strobe: cs=%b wn=%b addr=%0d wd=%h required cs=1 wn=0 addr=%0d wd=%h",
                         tag, chipselect, write_n, address, writedata, a, d);
            end
            @(negedge clk);
        end else begin
            for (int k = 0; k <= RW; k++) begin
                nChecks++;
                if ({chipselect, write_n, address, rsp_valid} !== {1'b1, 1'b1, a, 1'b0}) begin
                    nFails++;
                    $display("[TB] FAIL %s_rdhold%0d: cs=%b wn=%b addr=%0d rv=%b required cs=1 wn=1 addr=%0d rv=0",
                             tag, k, chipselect, write_n, address, rsp_valid, a);
                end
                @(negedge clk);
            end
        end
        nChecks++;
        if ({rsp_valid, chipselect, rsp_data} !== {1'b1, 1'b0, expRsp}) begin
            nFails++;
            $display("[TB] FAIL %s_rsp: rv=%b cs=%b data=%h required rv=1 cs=0 data=%h",
                     tag, rsp_valid, chipselect, rsp_data, expRsp);
        end
        @(negedge clk);
        nChecks++;
        if ({cmd_ready, rsp_valid} !== 2'b10 || rspCount != startRsp + 1) begin
            nFails++;
            $display("[TB] FAIL %s_done: ready=%b rv=%b pulses=%0d required ready=1 rv=0 pulses=1",
                     tag, cmd_ready, rsp_valid, rspCount - startRsp);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0;
        cmd_addr = '0; cmd_wdata = '0; inPort = '0;
        repeat (2) @(negedge clk);
        nChecks++;
        if ({cmd_ready, chipselect, write_n, address, writedata, rsp_valid, evt_valid, rsp_data, evt_data}
            !== {1'b1, 1'b0, 1'b1, {AW{1'b0}}, {DW{1'b0}}, 1'b0, 1'b0, {DW{1'b0}}, {DW{1'b0}}}) begin
            nFails++;
            $display("[TB] FAIL reset_state: ready=%b cs=%b wn=%b addr=%0d wd=%h rv=%b ev=%b rd=%h ed=%h required ready=1 cs=0 wn=1 rest 0",
                     cmd_ready, chipselect, write_n, address, writedata, rsp_valid, evt_valid, rsp_data, evt_data);
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        nChecks++;
        if (cmd_ready !== 1'b1 || rspCount != 0 || evtCount != 0) begin
            nFails++;
            $display("[TB] FAIL reset_release: ready=%b rsp=%0d evt=%0d required ready=1 rsp=0 evt=0",
                     cmd_ready, rspCount, evtCount);
        end
    endtask

    task automatic test_random_cmds();
        logic          wr;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int            pick;
        for (int i = 0; i < 8; i++) begin
            wr   = 1'($urandom_range(0, 1));
            pick = int'($urandom_range(0, 2));
            a    = (pick == 0) ? 2'd0 : (pick == 1) ? 2'd1 : 2'd3;
            d    = $urandom;
            inPort = $urandom;
            run_cmd(wr, a, d, (a == 2'd0) ? inPort : shadow[a], $sformatf("rand%0d", i));
            if (wr) shadow[a] = d;
        end
    endtask

    task automatic test_read_data();
        inPort = 32'd1;
        run_cmd(1'b0, 2'd0, 32'h0, 32'd1, "rd_data");
    endtask

    task automatic test_write_mask();
        inPort = 32'd0;
        run_cmd(1'b1, 2'd2, 32'd1, 32'd0, "wr_mask");
        shadow[2] = 32'd1;
    endtask

    task automatic test_interrupt();
        int startRsp;
        int startEvt;
        int found;
        logic [DW-1:0] seenData;
        startRsp = rspCount; startEvt = evtCount; found = 0; seenData = '0;
        @(negedge clk);
        inPort = 32'd1;
        @(negedge clk);
        nChecks++;
        if (cmd_ready !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL irq_ready: cmd_ready=%b required 0", cmd_ready);
        end
        @(negedge clk);
        nChecks++;
        if ({chipselect, write_n, address} !== {1'b1, 1'b1, 2'd0}) begin
            nFails++;
            $display("[TB] FAIL irq_launch: cs=%b wn=%b addr=%0d required cs=1 wn=1 addr=0",
                     chipselect, write_n, address);
        end
        for (int i = 0; i < 20 && found == 0; i++) begin
            @(negedge clk);
            if (evt_valid) begin
                found = 1;
                seenData = evt_data;
            end
        end
        nChecks++;
        if (found != 1 || seenData !== 32'd1) begin
            nFails++;
            $display("[TB] FAIL irq_event: seen=%0d data=%h required seen=1 data=00000001", found, seenData);
        end
        repeat (3) @(negedge clk);
        nChecks++;
        if (rspCount != startRsp || evtCount != startEvt + 1) begin
            nFails++;
            $display("[TB] FAIL irq_counts: rsp=%0d evt=%0d required rsp=0 evt=1",
                     rspCount - startRsp, evtCount - startEvt);
        end
        inPort = 32'd0;
        @(negedge clk);
    endtask

    task automatic test_simultaneous();
        int evtAt;
        int rspAt;
        int accAt;
        logic [DW-1:0] evtD;
        logic [DW-1:0] rspD;
        logic [DW-1:0] wd;
        evtAt = -1; rspAt = -1; accAt = -1; evtD = '0; rspD = '1;
        wd = $urandom;
        @(negedge clk);
        inPort = 32'd1;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 2'd1; cmd_wdata = wd;
        nChecks++;
        if (cmd_ready !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL simul_ready: cmd_ready=%b required 0", cmd_ready);
        end
        for (int i = 0; i < 40; i++) begin
            if (cmd_valid && cmd_ready && accAt < 0) accAt = i;
            @(negedge clk);
            if (accAt >= 0) cmd_valid = 1'b0;
            if (evt_valid && evtAt < 0) begin evtAt = i; evtD = evt_data; end
            if (rsp_valid && rspAt < 0) begin rspAt = i; rspD = rsp_data; end
        end
        shadow[1] = wd;
        nChecks++;
        if (evtAt < 0 || accAt <= evtAt || rspAt <= accAt) begin
            nFails++;
            $display("[TB] FAIL simul_order: evt=%0d accept=%0d rsp=%0d required evt < accept < rsp",
                     evtAt, accAt, rspAt);
        end
        nChecks++;
        if (evtD !== 32'd1 || rspD !== 32'd0 || slaveRegs[1] !== wd) begin
            nFails++;
            $display("[TB] FAIL simul_data: evt=%h rsp=%h reg1=%h required evt=00000001 rsp=0 reg1=%h",
                     evtD, rspD, slaveRegs[1], wd);
        end
        inPort = 32'd0;
        @(negedge clk);
    endtask

    task automatic test_coalesce();
        int startRsp;
        int startEvt;
        logic [4:0] pattern;
        pattern = 5'b10101;
        startRsp = rspCount; startEvt = evtCount;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 2'd1;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int i = 4; i >= 0; i--) begin
            inPort = {31'd0, pattern[i]};
            @(negedge clk);
        end
        repeat (15) @(negedge clk);
        nChecks++;
        if (evtCount != startEvt + 1 || rspCount != startRsp + 1) begin
            nFails++;
            $display("[TB] FAIL coalesce_counts: evt=%0d rsp=%0d required evt=1 rsp=1",
                     evtCount - startEvt, rspCount - startRsp);
        end
        nChecks++;
        if (evt_data !== 32'd1 || rsp_data !== shadow[1]) begin
            nFails++;
            $display("[TB] FAIL coalesce_data: evt=%h rsp=%h required evt=00000001 rsp=%h",
                     evt_data, rsp_data, shadow[1]);
        end
        inPort = 32'd0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_rd();
        int startRsp;
        startRsp = rspCount;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 2'd3; cmd_wdata = $urandom | 32'd1;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        nChecks++;
        if ({chipselect, write_n, address, writedata, rsp_valid, evt_valid, rsp_data, evt_data, cmd_ready}
            !== {1'b0, 1'b1, {AW{1'b0}}, {DW{1'b0}}, 1'b0, 1'b0, {DW{1'b0}}, {DW{1'b0}}, 1'b1}) begin
            nFails++;
            $display("[TB] FAIL midrd_reset: cs=%b wn=%b addr=%0d wd=%h rv=%b ev=%b rd=%h ed=%h ready=%b required cs=0 wn=1 ready=1 rest 0",
                     chipselect, write_n, address, writedata, rsp_valid, evt_valid, rsp_data, evt_data, cmd_ready);
        end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        nChecks++;
        if (rspCount != startRsp || cmd_ready !== 1'b1 || chipselect !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL midrd_release: rsp=%0d ready=%b cs=%b required rsp=0 ready=1 cs=0",
                     rspCount - startRsp, cmd_ready, chipselect);
        end
        run_cmd(1'b0, 2'd3, 32'h0, shadow[3], "after_reset");
    endtask

    initial begin
        test_reset();
        test_random_cmds();
        test_read_data();
        test_write_mask();
        test_interrupt();
        test_simultaneous();
        test_coalesce();
        test_reset_mid_rd();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

endmodule
